mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared core memory definitions: memory op encoding, byte-lane width and the
// arbiter state encoding used by mem_arbiter.
package mem_arbiter_pkg;

   typedef enum logic {
      CORE_MEM_OP_LOAD  = 1'b0,
      CORE_MEM_OP_STORE = 1'b1
   } core_mem_op_e;

   localparam int MEM_BYTE_EN_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_I = 2'd1,
      ST_WAIT_D = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/load-store) arbiter onto a single memory port with one
// outstanding read, dbus priority and a bounded dbus streak to avoid ibus starvation.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ibus_req,
   input  logic [31:0]              ibus_addr,
   output logic                     ibus_ready,
   output logic                     ibus_rvalid,
   output logic [31:0]              ibus_rdata,
   input  logic                     dbus_req,
   input  logic                     dbus_wen,
   input  logic [31:0]              dbus_addr,
   input  logic [31:0]              dbus_wdata,
   input  logic [MEM_BYTE_EN_W-1:0] dbus_byte_en,
   output logic                     dbus_ready,
   output logic                     dbus_rvalid,
   output logic [31:0]              dbus_rdata,
   output logic                     mem_req,
   output logic                     mem_wen,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [MEM_BYTE_EN_W-1:0] mem_byte_en,
   input  logic                     mem_ready,
   input  logic                     mem_rvalid,
   input  logic [31:0]              mem_rdata
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_e    state_q, state_d;
   logic [SW-1:0] d_streak_q, d_streak_d;
   logic          lock_q, lock_d;
   logic          lock_dsel_q, lock_dsel_d;
   logic          win_dbus;
   logic          idle;
   logic          accept;

   always_comb begin
      // A stalled request keeps its grant even if the other port raises req.
      win_dbus = dbus_req && !(ibus_req && (d_streak_q == STREAK_MAX));
      if (lock_q) begin
         win_dbus = lock_dsel_q;
      end

      idle        = (state_q == ST_IDLE) && !rst;
      mem_req     = idle && (ibus_req || dbus_req);
      mem_wen     = win_dbus ? dbus_wen     : CORE_MEM_OP_LOAD;
      mem_addr    = win_dbus ? dbus_addr    : ibus_addr;
      mem_wdata   = win_dbus ? dbus_wdata   : '0;
      mem_byte_en = win_dbus ? dbus_byte_en : '1;

      ibus_ready  = mem_req && !win_dbus && mem_ready;
      dbus_ready  = mem_req &&  win_dbus && mem_ready;
      accept      = mem_req && mem_ready;

      ibus_rvalid = !rst && (state_q == ST_WAIT_I) && mem_rvalid;
      dbus_rvalid = !rst && (state_q == ST_WAIT_D) && mem_rvalid;
      ibus_rdata  = mem_rdata;
      dbus_rdata  = mem_rdata;
   end

   always_comb begin
      state_d     = state_q;
      lock_d      = mem_req && !mem_ready;
      lock_dsel_d = win_dbus;
      d_streak_d  = d_streak_q;

      case (state_q)
         ST_IDLE: begin
            // Stores retire at acceptance; only reads wait for a response.
            if (accept && !mem_wen) begin
               state_d = win_dbus ? ST_WAIT_D : ST_WAIT_I;
            end
         end
         ST_WAIT_I, ST_WAIT_D: begin
            if (mem_rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!ibus_req || ibus_ready) begin
         d_streak_d = '0;
      end else if (dbus_ready && (d_streak_q != STREAK_MAX)) begin
         d_streak_d = d_streak_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         d_streak_q <= '0;
         lock_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         d_streak_q <= d_streak_d;
         lock_q     <= lock_d;
      end
      lock_dsel_q <= lock_dsel_d;
   end

endmodule
